fht_frame_sched: RTL and testbench

Frame-level scheduler that owns the four FHT data banks between frames. It performs three steps per frame:
- Loads one frame of samples from a host stream into the banks.
- Hands the banks to fht_control and pulses its start input, then waits for completion.
- Streams the transformed frame back out under valid/ready.

It sits between the host interface and fht_control, and drives the bank-port mux select.

---
 rtl/fht_sched_pkg.sv | 28 ++
 rtl/fht_out_stage.sv | 66 ++++++
 rtl/fht_frame_sched.sv | 171 +++++++++++++++++
 tb/tb_fht_frame_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_sched_pkg.sv
// rtl/fht_sched_pkg.sv - shared state encoding and index helpers for the FHT frame scheduler
package fht_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_UNLOAD
    } sched_state_t;

    // Samples per frame: four banks of 2^a_bit words each.
    function automatic int frame_len(input int a_bit);
        return 4 << a_bit;
    endfunction

    // Sample index k interleaves across banks: bank = k mod 4.
    function automatic logic [1:0] idx_bank(input logic [31:0] k);
        return 2'(k);
    endfunction

    // Word address inside the bank: k / 4 (caller truncates to A_BIT).
    function automatic logic [31:0] idx_addr(input logic [31:0] k);
        return k >> 2;
    endfunction

endpackage

// File: rtl/fht_out_stage.sv
// rtl/fht_out_stage.sv - read issue control and 2-entry skid FIFO for the frame unload path
module fht_out_stage
    import fht_sched_pkg::*;
#(
    parameter int D_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_req,
    input  logic             issue_last,
    output logic             issue,
    input  logic [D_BIT-1:0] rd_data,
    output logic [D_BIT-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    logic [D_BIT-1:0] mem [2];
    logic [1:0]       last_mem;
    logic             wptr;
    logic             rptr;
    logic [1:0]       count;
    logic             in_flight;
    logic             in_flight_last;
    logic             pop;
    logic [2:0]       occ;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;

    // A read is only issued when its word is guaranteed a FIFO slot on arrival.
    assign occ   = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
    assign issue = issue_req && (occ < 3'd2);

    // Zero the data bus when empty so idle output is deterministic.
    assign out_data = out_valid ? mem[rptr] : '0;
    assign out_last = out_valid & last_mem[rptr];

    // Track the in-flight read and capture returning bank data one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]         <= '0;
            mem[1]         <= '0;
            last_mem       <= 2'b00;
            wptr           <= 1'b0;
            rptr           <= 1'b0;
            count          <= 2'd0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= issue;
            in_flight_last <= issue & issue_last;
            if (in_flight) begin
                mem[wptr]      <= rd_data;
                last_mem[wptr] <= in_flight_last;
                wptr           <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, in_flight} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fht_frame_sched.sv
// rtl/fht_frame_sched.sv - frame scheduler: load banks, run fht_control, unload banks
module fht_frame_sched
    import fht_sched_pkg::*;
#(
    parameter int A_BIT   = 8,
    parameter int D_BIT   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iGO,
    input  logic [D_BIT-1:0] iIN_DATA,
    input  logic             iIN_VALID,
    output logic             oIN_READY,
    output logic [D_BIT-1:0] oOUT_DATA,
    output logic             oOUT_VALID,
    input  logic             iOUT_READY,
    output logic             oOUT_LAST,
    output logic             oHOST_OWN,
    output logic [1:0]       oBANK,
    output logic [A_BIT-1:0] oADDR,
    output logic [D_BIT-1:0] oWR_DATA,
    output logic             oWE,
    output logic             oRD_EN,
    input  logic [D_BIT-1:0] iRD_DATA,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oERR
);

    localparam int            N        = frame_len(A_BIT);
    localparam int            KW       = A_BIT + 2;
    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
    localparam logic [KW:0]   RD_END   = (KW + 1)'(N);
    localparam logic [15:0]   TMR_LAST = 16'(TIMEOUT - 1);

    sched_state_t  state;
    sched_state_t  state_nxt;
    logic [KW-1:0] wr_cnt;
    logic [KW:0]   rd_cnt;
    logic [15:0]   tmr;
    logic          done_q;
    logic          err_q;
    logic          finish;
    logic          abort;

    logic          in_hs;
    logic          waiting;
    logic          timeout_hit;
    logic          issue_req;
    logic          issue_last;
    logic          rd_issue;
    logic          out_valid;
    logic          out_last;
    logic          last_pop;
    logic [KW:0]   cur_idx;

    assign in_hs       = (state == S_LOAD) && iIN_VALID;
    assign waiting     = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign timeout_hit = (tmr == TMR_LAST);
    assign issue_req   = (state == S_UNLOAD) && (rd_cnt < RD_END);
    assign issue_last  = (rd_cnt[KW-1:0] == K_LAST);
    assign last_pop    = out_valid && iOUT_READY && out_last;

    fht_out_stage #(
        .D_BIT (D_BIT)
    ) u_out (
        .clk        (iCLK),
        .rst_n      (iRESET),
        .issue_req  (issue_req),
        .issue_last (issue_last),
        .issue      (rd_issue),
        .rd_data    (iRD_DATA),
        .out_data   (oOUT_DATA),
        .out_valid  (out_valid),
        .out_ready  (iOUT_READY),
        .out_last   (out_last)
    );

    // Next-state selection; a normal fht_control handshake wins over a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (iGO) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (in_hs && (wr_cnt == K_LAST)) state_nxt = S_START;
            end
            S_START: begin
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!iFHT_RDY) begin
                    state_nxt = S_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                    abort     = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (iFHT_RDY) begin
                    state_nxt = S_UNLOAD;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                    abort     = 1'b1;
                end
            end
            S_UNLOAD: begin
                if (last_pop) begin
                    state_nxt = S_IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, frame counters, wait timer and completion pulses.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state  <= S_IDLE;
            wr_cnt <= '0;
            rd_cnt <= '0;
            tmr    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= finish;
            err_q  <= abort;
            if ((state == S_IDLE) && iGO) begin
                wr_cnt <= '0;
            end else if (in_hs) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if ((state == S_WAIT_DONE) && iFHT_RDY) begin
                rd_cnt <= '0;
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (state == S_START) begin
                tmr <= '0;
            end else if (waiting) begin
                tmr <= tmr + 16'd1;
            end
        end
    end

    assign cur_idx = (state == S_UNLOAD) ? rd_cnt :
                     (state == S_LOAD)   ? {1'b0, wr_cnt} : '0;

    assign oBANK      = idx_bank(32'(cur_idx));
    assign oADDR      = A_BIT'(idx_addr(32'(cur_idx)));
    assign oIN_READY  = (state == S_LOAD);
    assign oWE        = in_hs;
    assign oWR_DATA   = (state == S_LOAD) ? iIN_DATA : '0;
    assign oRD_EN     = rd_issue;
    assign oOUT_VALID = out_valid;
    assign oOUT_LAST  = out_last;
    assign oHOST_OWN  = !((state == S_START) || waiting);
    assign oFHT_START = (state == S_START);
    assign oBUSY      = (state != S_IDLE);
    assign oDONE      = done_q;
    assign oERR       = err_q;

endmodule

// File: tb/tb_fht_frame_sched.sv
// tb/tb_fht_frame_sched.sv - self-checking bench for fht_frame_sched
module tb_fht_frame_sched;

    localparam int A_BIT = 2;
    localparam int D_BIT = 16;
    localparam int N     = 16;

    logic             iCLK = 1'b0;
    logic             iRESET;
    logic             iGO;
    logic [D_BIT-1:0] iIN_DATA;
    logic             iIN_VALID;
    logic             oIN_READY;
    logic [D_BIT-1:0] oOUT_DATA;
    logic             oOUT_VALID;
    logic             iOUT_READY;
    logic             oOUT_LAST;
    logic             oHOST_OWN;
    logic [1:0]       oBANK;
    logic [A_BIT-1:0] oADDR;
    logic [D_BIT-1:0] oWR_DATA;
    logic             oWE;
    logic             oRD_EN;
    logic [D_BIT-1:0] iRD_DATA;
    logic             oFHT_START;
    logic             iFHT_RDY;
    logic             oBUSY;
    logic             oDONE;
    logic             oERR;

    fht_frame_sched #(
        .A_BIT   (A_BIT),
        .D_BIT   (D_BIT),
        .TIMEOUT (20)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iGO        (iGO),
        .iIN_DATA   (iIN_DATA),
        .iIN_VALID  (iIN_VALID),
        .oIN_READY  (oIN_READY),
        .oOUT_DATA  (oOUT_DATA),
        .oOUT_VALID (oOUT_VALID),
        .iOUT_READY (iOUT_READY),
        .oOUT_LAST  (oOUT_LAST),
        .oHOST_OWN  (oHOST_OWN),
        .oBANK      (oBANK),
        .oADDR      (oADDR),
        .oWR_DATA   (oWR_DATA),
        .oWE        (oWE),
        .oRD_EN     (oRD_EN),
        .iRD_DATA   (iRD_DATA),
        .oFHT_START (oFHT_START),
        .iFHT_RDY   (iFHT_RDY),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE),
        .oERR       (oERR)
    );

    always #5 iCLK = ~iCLK;

    // Four-bank memory model; read data returns one cycle after oRD_EN.
    logic [D_BIT-1:0] bank_mem [4][4];
    logic [D_BIT-1:0] rd_q = '0;
    assign iRD_DATA = rd_q;
    always @(posedge iCLK) begin
        if (oWE) bank_mem[oBANK][oADDR] <= oWR_DATA;
        if (oRD_EN) rd_q <= bank_mem[oBANK][oADDR];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame-level monitor, sampled on the falling edge.
    logic [D_BIT-1:0] base = '0;
    logic [D_BIT-1:0] exp_d;
    logic [D_BIT-1:0] prev_data = '0;
    logic             prev_stall = 1'b0;
    int cyc = 0, out_idx = 0;
    int mon_start = 0, mon_wr = 0, mon_hs = 0, mon_valid = 0, mon_done = 0, mon_err = 0;
    int mon_dbad = 0, mon_sbad = 0, mon_mux = 0;
    int start_cyc = 0, err_cyc = 0, first_rd_cyc = -1, first_valid_cyc = -1, last_hs_cyc = 0;

    always @(negedge iCLK) begin
        cyc = cyc + 1;
        if (oFHT_START) begin
            mon_start++;
            out_idx = 0;
            start_cyc = cyc;
            first_rd_cyc = -1;
            first_valid_cyc = -1;
        end
        if (oWE && oIN_READY) mon_wr++;
        if (oRD_EN && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (oOUT_VALID) begin
            mon_valid++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (oOUT_LAST !== (out_idx == N - 1)) mon_dbad++;
            if (iOUT_READY) begin
                exp_d = base + 16'(out_idx);
                if (oOUT_DATA !== exp_d) mon_dbad++;
                out_idx++;
                mon_hs++;
                last_hs_cyc = cyc;
            end
        end else if (oOUT_LAST) begin
            mon_dbad++;
        end
        if (iRESET && prev_stall && (!oOUT_VALID || oOUT_DATA !== prev_data)) mon_sbad++;
        prev_stall = iRESET && oOUT_VALID && !iOUT_READY;
        prev_data  = oOUT_DATA;
        if ((oWE || oRD_EN) && !oHOST_OWN) mon_mux++;
        if (oDONE) mon_done++;
        if (oERR) begin
            mon_err++;
            err_cyc = cyc;
        end
    end

    typedef struct {
        string name;
        int    gap;
        int    ready_pct;
        int    rdy_low;
        bit    go_noise;
        int    rst_after;
        int    exp_out;
        int    exp_done;
        int    exp_err;
        bit    chk_thru;
    } vec_t;

    vec_t tbl [7];

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_host_own"}, int'(oHOST_OWN), 1);
        check({tag, "_ctrl"}, int'({oIN_READY, oOUT_VALID, oOUT_LAST, oBANK, oADDR, oWE,
                                   oRD_EN, oFHT_START, oBUSY, oDONE, oERR}), 0);
        check({tag, "_out_data"}, int'(oOUT_DATA), 0);
        check({tag, "_wr_data"}, int'(oWR_DATA), 0);
    endtask

    task automatic run_frame(input vec_t v, input int n);
        int s_start, s_wr, s_hs, s_valid, s_done, s_err, s_dbad, s_sbad, s_mux;
        int in_k, rdy_cnt, cycles, hs_n, bad;
        bit fin, hs_in, st;
        base    = 16'((n + 1) * 'h1111);
        s_start = mon_start; s_wr = mon_wr; s_hs = mon_hs; s_valid = mon_valid;
        s_done  = mon_done;  s_err = mon_err; s_dbad = mon_dbad; s_sbad = mon_sbad;
        s_mux   = mon_mux;
        in_k = 0; rdy_cnt = 0; cycles = 0; fin = 0;
        @(posedge iCLK); #1;
        iGO        = 1'b1;
        iFHT_RDY   = 1'b1;
        iIN_VALID  = ($urandom_range(99) >= v.gap);
        iIN_DATA   = base;
        iOUT_READY = ($urandom_range(99) < v.ready_pct);
        while (!fin && cycles < 400) begin
            @(negedge iCLK);
            hs_in = iIN_VALID && oIN_READY;
            st    = oFHT_START;
            @(posedge iCLK); #1;
            cycles++;
            if (hs_in) in_k++;
            if (st && v.rdy_low >= 0) rdy_cnt = v.rdy_low;
            if (v.rdy_low < 0) begin
                iFHT_RDY = 1'b1;
            end else if (rdy_cnt > 0) begin
                iFHT_RDY = 1'b0;
                rdy_cnt--;
            end else begin
                iFHT_RDY = 1'b1;
            end
            iIN_VALID  = (in_k < N) && ($urandom_range(99) >= v.gap);
            iIN_DATA   = base + 16'(in_k);
            iOUT_READY = ($urandom_range(99) < v.ready_pct);
            hs_n = mon_hs - s_hs;
            iGO  = v.go_noise && ((in_k > 2 && in_k < 12) || (hs_n > 2 && hs_n < 12));
            if (mon_done != s_done || mon_err != s_err) fin = 1;
            if (v.rst_after > 0 && hs_n >= v.rst_after) fin = 1;
        end
        check({v.name, "_finished"}, int'(fin), 1);
        if (v.rst_after > 0) begin
            iRESET = 1'b0;
            #1;
            chk_reset_outputs({v.name, "_reset"});
            iGO = 1'b0; iIN_VALID = 1'b0; iOUT_READY = 1'b0; iFHT_RDY = 1'b1;
            repeat (3) @(negedge iCLK);
            iRESET = 1'b1;
            return;
        end
        iGO = 1'b0; iIN_VALID = 1'b0; iOUT_READY = 1'b0; iFHT_RDY = 1'b1;
        repeat (25) @(posedge iCLK);
        @(negedge iCLK); #1;
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (bank_mem[k % 4][k / 4] !== base + 16'(k)) bad++;
        end
        check({v.name, "_start_pulses"}, mon_start - s_start, 1);
        check({v.name, "_writes"}, mon_wr - s_wr, N);
        check({v.name, "_bank_map"}, bad, 0);
        check({v.name, "_outputs"}, mon_hs - s_hs, v.exp_out);
        check({v.name, "_done"}, mon_done - s_done, v.exp_done);
        check({v.name, "_err"}, mon_err - s_err, v.exp_err);
        check({v.name, "_data_order_last"}, mon_dbad - s_dbad, 0);
        check({v.name, "_stall_stable"}, mon_sbad - s_sbad, 0);
        check({v.name, "_mux_safe"}, mon_mux - s_mux, 0);
        check({v.name, "_idle_busy"}, int'(oBUSY), 0);
        if (v.chk_thru) begin
            check({v.name, "_burst_span"}, last_hs_cyc - first_valid_cyc, N - 1);
            check({v.name, "_first_latency"}, first_valid_cyc - first_rd_cyc, 2);
        end
        if (v.exp_err != 0) begin
            check({v.name, "_err_delay"}, err_cyc - start_cyc, 21);
            check({v.name, "_no_valid"}, mon_valid - s_valid, 0);
            check({v.name, "_host_own"}, int'(oHOST_OWN), 1);
        end
    endtask

    initial begin
        tbl[0] = '{"basic",     0, 100, 10, 1'b0, 0, 16, 1, 0, 1'b1};
        tbl[1] = '{"random",   50,  50, 10, 1'b0, 0, 16, 1, 0, 1'b0};
        tbl[2] = '{"go_noise", 20,  70, 10, 1'b1, 0, 16, 1, 0, 1'b0};
        tbl[3] = '{"timeout",   0, 100, -1, 1'b0, 0,  0, 0, 1, 1'b0};
        tbl[4] = '{"recover",  30,  40,  3, 1'b0, 0, 16, 1, 0, 1'b0};
        tbl[5] = '{"midreset",  0, 100, 10, 1'b0, 7,  0, 0, 0, 1'b0};
        tbl[6] = '{"clean",     0, 100, 10, 1'b0, 0, 16, 1, 0, 1'b1};

        iRESET = 1'b0; iGO = 1'b0; iIN_DATA = 16'h5A5A; iIN_VALID = 1'b0;
        iOUT_READY = 1'b0; iFHT_RDY = 1'b1;
        #12;
        chk_reset_outputs("por");
        @(negedge iCLK);
        iRESET = 1'b1;
        repeat (2) @(posedge iCLK);
        #1;
        check("idle_in_ready", int'(oIN_READY), 0);

        for (int i = 0; i < 7; i++) run_frame(tbl[i], i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
